// File: rtl/mux_pkg.sv
// Shared constants and width helper for the scanning mux.
package mux_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mux_scan_ctr.sv
// Dwell counter and wrapping channel pointer for auto-scan.
module mux_scan_ctr
  import mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int DWELL = 4,
  parameter int SELW  = clog2_min1(N_CH),
  parameter int CW    = clog2_min1(DWELL)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            stall,
  input  logic            clear,
  output logic            tick,
  output logic [SELW-1:0] ptr
);
  localparam logic [CW-1:0]   CMAX = CW'(DWELL - 1);
  localparam logic [SELW-1:0] PMAX = SELW'(N_CH - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CMAX);

  // At CMAX the count saturates under stall so no channel is skipped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      ptr <= '0;
    end else if (clear) begin
      cnt <= '0;
      ptr <= '0;
    end else if (en) begin
      if (cnt != CMAX) begin
        cnt <= cnt + 1'b1;
      end else if (!stall) begin
        cnt <= '0;
        ptr <= (ptr == PMAX) ? '0 : ptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_scan_n.sv
// N-channel registered mux with manual select or round-robin
// scan, delivering samples on a valid/ready handshake.
module mux_scan_n
  import mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int DWELL = 4,
  localparam int SELW = clog2_min1(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] din,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  input  logic              en,
  input  logic              out_ready,
  output logic [W-1:0]      dout,
  output logic [SELW-1:0]   ch_out,
  output logic              out_valid,
  output logic              err
);
  logic            mode_q;
  logic            mode_chg;
  logic            is_scan;
  logic            slot_free;
  logic            tick;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] idx;
  logic            in_rng;
  logic [W-1:0]    mux_d;
  logic            cap;
  logic            err_d;

  assign mode_chg  = (mode != mode_q);
  assign is_scan   = (mode == MODE_SCAN);
  assign slot_free = !out_valid || out_ready;

  mux_scan_ctr #(
    .N_CH  (N_CH),
    .DWELL (DWELL)
  ) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en && is_scan),
    .stall (!slot_free),
    .clear (!is_scan || mode_chg),
    .tick  (tick),
    .ptr   (ptr)
  );

  always_comb begin
    idx    = is_scan ? ptr : sel;
    in_rng = int'(idx) < N_CH;
    mux_d  = '0;
    if (in_rng) mux_d = din[int'(idx)*W +: W];
    cap    = !mode_chg && slot_free && (is_scan ? tick : en);
    err_d  = cap && !is_scan && !in_rng;
  end

  // mode_q loads the live mode in reset so release is not a switch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout      <= '0;
      ch_out    <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      mode_q    <= mode;
    end else begin
      mode_q <= mode;
      err    <= err_d;
      if (cap) begin
        dout      <= mux_d;
        ch_out    <= idx;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n: three instances with
// different geometries, directed vectors, negedge monitors.
module tb_mux_scan_n;
  typedef struct {
    int ch;
    int d;
    int e;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  // A: N_CH=8 W=1 DWELL=4
  logic       a_rst, a_mode, a_en, a_rdy;
  logic [7:0] a_din = 8'b1011_0010;
  logic [2:0] a_sel, a_ch;
  logic [0:0] a_dout;
  logic       a_vld, a_err;
  // B: N_CH=6 W=1 DWELL=4
  logic       b_rst, b_mode, b_en, b_rdy;
  logic [5:0] b_din = 6'b10_1101;
  logic [2:0] b_sel, b_ch;
  logic [0:0] b_dout;
  logic       b_vld, b_err;
  // C: N_CH=4 W=4 DWELL=4
  logic        c_rst, c_mode, c_en, c_rdy;
  logic [15:0] c_din = 16'hA5C3;
  logic [1:0]  c_sel, c_ch;
  logic [3:0]  c_dout;
  logic        c_vld, c_err;

  mux_scan_n #(.N_CH(8), .W(1), .DWELL(4)) u_a (
    .clk(clk), .rst_n(a_rst), .din(a_din), .mode(a_mode),
    .sel(a_sel), .en(a_en), .out_ready(a_rdy),
    .dout(a_dout), .ch_out(a_ch), .out_valid(a_vld),
    .err(a_err));

  mux_scan_n #(.N_CH(6), .W(1), .DWELL(4)) u_b (
    .clk(clk), .rst_n(b_rst), .din(b_din), .mode(b_mode),
    .sel(b_sel), .en(b_en), .out_ready(b_rdy),
    .dout(b_dout), .ch_out(b_ch), .out_valid(b_vld),
    .err(b_err));

  mux_scan_n #(.N_CH(4), .W(4), .DWELL(4)) u_c (
    .clk(clk), .rst_n(c_rst), .din(c_din), .mode(c_mode),
    .sel(c_sel), .en(c_en), .out_ready(c_rdy),
    .dout(c_dout), .ch_out(c_ch), .out_valid(c_vld),
    .err(c_err));

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic miss(string nm);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected sample want none", nm);
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic exp_t mk(int ch, int d, int e);
    exp_t x;
    x.ch = ch;
    x.d  = d;
    x.e  = e;
    return x;
  endfunction

  always @(negedge clk) begin
    exp_t x;
    if (a_vld && a_rdy) begin
      if (qa.size() == 0) miss("a_extra");
      else begin
        x = qa.pop_front();
        chk("a_ch", int'(a_ch), x.ch);
        chk("a_dout", int'(a_dout), x.d);
        chk("a_err", int'(a_err), x.e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (b_vld && b_rdy) begin
      if (qb.size() == 0) miss("b_extra");
      else begin
        x = qb.pop_front();
        chk("b_ch", int'(b_ch), x.ch);
        chk("b_dout", int'(b_dout), x.d);
        chk("b_err", int'(b_err), x.e);
      end
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (c_vld && c_rdy) begin
      if (qc.size() == 0) miss("c_extra");
      else begin
        x = qc.pop_front();
        chk("c_ch", int'(c_ch), x.ch);
        chk("c_dout", int'(c_dout), x.d);
        chk("c_err", int'(c_err), x.e);
      end
    end
  end

  initial begin
    #60000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 0; a_mode = 0; a_en = 0; a_rdy = 1; a_sel = 0;
    b_rst = 0; b_mode = 0; b_en = 0; b_rdy = 1; b_sel = 0;
    c_rst = 0; c_mode = 0; c_en = 0; c_rdy = 1; c_sel = 0;
    step(2);
    chk("rst_dout", int'(a_dout), 0);
    chk("rst_ch", int'(a_ch), 0);
    chk("rst_vld", int'(a_vld), 0);
    chk("rst_err", int'(a_err), 0);
    a_rst = 1; b_rst = 1; c_rst = 1;
    step(1);

    // manual sweep
    a_en = 1;
    for (int k = 0; k < 8; k++) begin
      a_sel = 3'(k);
      qa.push_back(mk(k, int'(a_din[k]), 0));
      step(1);
      chk("sweep_vld", int'(a_vld), 1);
    end
    a_en = 0;
    step(1);
    chk("consume_vld", int'(a_vld), 0);

    // scan wrap from reset release
    a_rst = 0; a_mode = 1; a_en = 1;
    step(1);
    a_rst = 1;
    for (int k = 0; k < 9; k++)
      qa.push_back(mk(k % 8, int'(a_din[k % 8]), 0));
    step(3);
    chk("scan_first_vld0", int'(a_vld), 0);
    step(1);
    chk("scan_first_vld1", int'(a_vld), 1);
    step(32);
    chk("scan_wrap_ch", int'(a_ch), 0);

    // backpressure at ch 2
    a_rst = 0;
    step(1);
    a_rst = 1;
    for (int k = 0; k < 3; k++)
      qa.push_back(mk(k, int'(a_din[k]), 0));
    step(12);
    a_rdy = 0;
    chk("bp_ch", int'(a_ch), 2);
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("bp_hold_ch", int'(a_ch), 2);
      chk("bp_hold_vld", int'(a_vld), 1);
    end
    chk("bp_hold_dout", int'(a_dout), 0);
    qa.push_back(mk(3, int'(a_din[3]), 0));
    a_rdy = 1;
    step(1);
    chk("bp_next_ch", int'(a_ch), 3);
    chk("bp_next_vld", int'(a_vld), 1);

    // reset while ch 5 pending
    qa.push_back(mk(4, int'(a_din[4]), 0));
    step(8);
    a_rdy = 0;
    chk("pend_ch", int'(a_ch), 5);
    a_rst = 0;
    step(1);
    chk("mid_rst_vld", int'(a_vld), 0);
    chk("mid_rst_ch", int'(a_ch), 0);
    chk("mid_rst_dout", int'(a_dout), 0);
    chk("mid_rst_err", int'(a_err), 0);
    a_rst = 1; a_rdy = 1;
    qa.push_back(mk(0, int'(a_din[0]), 0));
    step(3);
    chk("post_rst_vld0", int'(a_vld), 0);
    step(1);
    chk("post_rst_ch", int'(a_ch), 0);
    chk("post_rst_vld1", int'(a_vld), 1);
    a_en = 0;

    // out of range on N_CH=6
    b_en = 1;
    b_sel = 3'd7; qb.push_back(mk(7, 0, 1)); step(1);
    b_sel = 3'd5; qb.push_back(mk(5, 1, 0)); step(1);
    b_sel = 3'd6; qb.push_back(mk(6, 0, 1)); step(1);
    b_sel = 3'd0; qb.push_back(mk(0, 1, 0)); step(1);
    b_en = 0;
    step(1);
    chk("oor_err_idle", int'(b_err), 0);
    chk("oor_vld_idle", int'(b_vld), 0);

    // mode switch with W=4
    c_rst = 0; c_mode = 1; c_en = 1;
    step(1);
    c_rst = 1;
    qc.push_back(mk(0, 4'h3, 0));
    qc.push_back(mk(1, 4'hC, 0));
    qc.push_back(mk(2, 4'h5, 0));
    step(12);
    chk("sw_scan_ch", int'(c_ch), 2);
    c_mode = 0; c_sel = 2'd1;
    step(1);
    chk("sw_no_cap_vld", int'(c_vld), 0);
    qc.push_back(mk(1, 4'hC, 0));
    step(1);
    chk("sw_man_dout", int'(c_dout), 4'hC);
    c_en = 0;
    step(1);
    c_mode = 1; c_en = 1;
    qc.push_back(mk(0, 4'h3, 0));
    step(4);
    chk("sw_back_vld0", int'(c_vld), 0);
    step(1);
    chk("sw_back_dout", int'(c_dout), 4'h3);
    chk("sw_back_ch", int'(c_ch), 0);
    c_en = 0;

    step(3);
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    chk("qc_empty", qc.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
